// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard sequencer: stage enables/flushes, run/wait/halt FSM, perf counters
//
// Purpose:
//   Central sequencer for the PC and the four pipeline registers
//   (if_id, id_ex, ex_mem, mem_wb). It resolves data-cache stalls,
//   load-use hazards, MEM-stage redirects, fetch misses and halt into
//   per-stage enables and flushes. It also keeps saturating counts of
//   stall cycles and of redirects taken.
//
// Ports:
//   CLK, RST             clock (rising edge) and synchronous active-high reset
//   ihit, dhit           instruction / data access complete this cycle
//   mem_dren, mem_dwen   data read / write request of the instruction in MEM
//   mem_redirect         taken branch / jump / jr resolved in MEM
//   mem_halt             halt instruction in MEM
//   ex_dren, ex_wsel     load in EX and its destination register
//   id_rs, id_rt         source registers of the instruction in ID
//   pc_en, pipe1..4_en   PC and pipeline-register enables
//   flush1..3            if_id / id_ex / ex_mem flushes
//   dmem_busy, halted    FSM is in DWAIT / HALT
//   stall_cnt            saturating count of cycles with pc_en=0 outside HALT
//   flush_cnt            saturating count of redirects taken
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             mem_redirect,
  input  logic             mem_halt,
  input  logic             ex_dren,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             pc_en,
  output logic             pipe1_en,
  output logic             pipe2_en,
  output logic             pipe3_en,
  output logic             pipe4_en,
  output logic             flush1,
  output logic             flush2,
  output logic             flush3,
  output logic             dmem_busy,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DWAIT = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_dreq;
  logic w_dstall;
  logic w_lu;
  logic w_redirect_take;
  logic w_stall_inc;

  assign w_dreq   = mem_dren | mem_dwen;
  assign w_dstall = w_dreq & ~dhit;
  // Register zero is hard-wired, so a load targeting it never creates a hazard.
  assign w_lu     = ex_dren & (ex_wsel != '0) &
                    ((ex_wsel == id_rs) | (ex_wsel == id_rt));

  // Stage controls, highest priority first.
  always_comb begin
    pc_en           = 1'b1;
    pipe1_en        = 1'b1;
    pipe2_en        = 1'b1;
    pipe3_en        = 1'b1;
    pipe4_en        = 1'b1;
    flush1          = 1'b0;
    flush2          = 1'b0;
    flush3          = 1'b0;
    w_redirect_take = 1'b0;
    if (RST) begin
      pc_en    = 1'b0;
      pipe1_en = 1'b0;
      pipe2_en = 1'b0;
      pipe3_en = 1'b0;
      pipe4_en = 1'b0;
      flush1   = 1'b1;
      flush2   = 1'b1;
      flush3   = 1'b1;
    end else if (r_state == S_HALT || w_dstall) begin
      // Whole pipe frozen, nothing squashed.
      pc_en    = 1'b0;
      pipe1_en = 1'b0;
      pipe2_en = 1'b0;
      pipe3_en = 1'b0;
      pipe4_en = 1'b0;
    end else if (mem_redirect) begin
      // Squash the three wrong-path instructions; the MEM instruction retires
      // and the PC loads the target even if the current fetch has not completed.
      flush1          = 1'b1;
      flush2          = 1'b1;
      flush3          = 1'b1;
      w_redirect_take = 1'b1;
    end else if (w_lu) begin
      // Hold PC and if_id, insert a bubble into EX.
      pc_en    = 1'b0;
      pipe1_en = 1'b0;
      flush2   = 1'b1;
    end else if (!ihit) begin
      // Fetch outstanding: hold PC, bubble into ID.
      pc_en  = 1'b0;
      flush1 = 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RUN: begin
        if (w_dstall)      w_next_state = S_DWAIT;
        else if (mem_halt) w_next_state = S_HALT;
      end
      S_DWAIT: begin
        // The access completes this cycle; a halt waiting behind it is
        // clocked into mem_wb on the same edge.
        if (dhit) w_next_state = mem_halt ? S_HALT : S_RUN;
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_RUN;
    endcase
  end

  assign w_stall_inc = ~pc_en & (r_state != S_HALT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_redirect_take && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign dmem_busy = ~RST & (r_state == S_DWAIT);
  assign halted    = ~RST & (r_state == S_HALT);
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST, ihit, dhit, mem_dren, mem_dwen, mem_redirect, mem_halt, ex_dren;
  logic [4:0] ex_wsel, id_rs, id_rt;

  logic        pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en;
  logic        flush1, flush2, flush3, dmem_busy, halted;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_en, s_pipe1_en, s_pipe2_en, s_pipe3_en, s_pipe4_en;
  logic        s_flush1, s_flush2, s_flush3, s_dmem_busy, s_halted;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.CNT_W(16), .REG_W(5)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .mem_dren(mem_dren), .mem_dwen(mem_dwen), .mem_redirect(mem_redirect),
    .mem_halt(mem_halt), .ex_dren(ex_dren), .ex_wsel(ex_wsel),
    .id_rs(id_rs), .id_rt(id_rt),
    .pc_en(pc_en), .pipe1_en(pipe1_en), .pipe2_en(pipe2_en),
    .pipe3_en(pipe3_en), .pipe4_en(pipe4_en),
    .flush1(flush1), .flush2(flush2), .flush3(flush3),
    .dmem_busy(dmem_busy), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(4), .REG_W(5)) dut_small (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .mem_dren(mem_dren), .mem_dwen(mem_dwen), .mem_redirect(mem_redirect),
    .mem_halt(mem_halt), .ex_dren(ex_dren), .ex_wsel(ex_wsel),
    .id_rs(id_rs), .id_rt(id_rt),
    .pc_en(s_pc_en), .pipe1_en(s_pipe1_en), .pipe2_en(s_pipe2_en),
    .pipe3_en(s_pipe3_en), .pipe4_en(s_pipe4_en),
    .flush1(s_flush1), .flush2(s_flush2), .flush3(s_flush3),
    .dmem_busy(s_dmem_busy), .halted(s_halted),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct {
    int          idx;
    logic        rst, ihit, dhit, redir, mhalt, exd;
    logic [1:0]  dq;
    logic [4:0]  wsel, rs, rt;
    logic [4:0]  en;
    logic [2:0]  fl;
    logic        busy, hlt, chk;
    logic [15:0] scnt, fcnt;
  } vec_t;

  localparam logic [4:0] EN_ALL = 5'b11111;
  localparam logic [4:0] EN_NO  = 5'b00000;
  localparam logic [4:0] EN_LU  = 5'b00111;
  localparam logic [4:0] EN_IM  = 5'b01111;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic void add(input logic rst, ihit, dhit, input logic [1:0] dq,
                              input logic redir, mhalt, exd, input logic [4:0] wsel, rs, rt,
                              input logic [4:0] en, input logic [2:0] fl,
                              input logic busy, hlt, chk, input logic [15:0] scnt, fcnt);
    vec_t v;
    v.idx = vecs.size(); v.rst = rst; v.ihit = ihit; v.dhit = dhit; v.dq = dq;
    v.redir = redir; v.mhalt = mhalt; v.exd = exd; v.wsel = wsel; v.rs = rs; v.rt = rt;
    v.en = en; v.fl = fl; v.busy = busy; v.hlt = hlt; v.chk = chk; v.scnt = scnt; v.fcnt = fcnt;
    vecs.push_back(v);
  endfunction

  // Scoreboard checker: one expected record per applied cycle, compared mid-cycle.
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      vec_t e;
      logic [4:0] g_en;
      logic [2:0] g_fl;
      logic       bad;
      e    = sb.pop_front();
      g_en = {pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en};
      g_fl = {flush1, flush2, flush3};
      bad  = (g_en !== e.en) || (g_fl !== e.fl) || (dmem_busy !== e.busy) || (halted !== e.hlt);
      if (e.chk) bad = bad || (stall_cnt !== e.scnt) || (flush_cnt !== e.fcnt);
      n_vec++;
      if (bad) begin
        n_miss++;
        $display("FAIL vec%0d: got en=%b fl=%b busy=%b halted=%b scnt=%0d fcnt=%0d, want en=%b fl=%b busy=%b halted=%b scnt=%0d fcnt=%0d",
                 e.idx, g_en, g_fl, dmem_busy, halted, stall_cnt, flush_cnt,
                 e.en, e.fl, e.busy, e.hlt, e.scnt, e.fcnt);
      end
    end
  end

  task automatic drive_idle(input logic rst, input logic ih);
    RST = rst; ihit = ih; dhit = 1'b0; mem_dren = 1'b0; mem_dwen = 1'b0;
    mem_redirect = 1'b0; mem_halt = 1'b0; ex_dren = 1'b0;
    ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  initial begin
    drive_idle(1'b1, 1'b0);
    //  rst ihit dhit dq    rd mh exd wsel rs    rt    en      fl      bsy hlt chk scnt fcnt
    // reset then idle run
    add(1, 0, 0, 2'b00, 0, 0, 0, 0,    0,    0,    EN_NO,  3'b111, 0, 0, 0, 0, 0);
    add(1, 0, 0, 2'b00, 0, 0, 0, 0,    0,    0,    EN_NO,  3'b111, 0, 0, 1, 0, 0);
    add(0, 1, 0, 2'b00, 0, 0, 0, 0,    0,    0,    EN_ALL, 3'b000, 0, 0, 1, 0, 0);
    add(0, 1, 0, 2'b00, 0, 0, 0, 0,    0,    0,    EN_ALL, 3'b000, 0, 0, 1, 0, 0);
    // data miss for three cycles, hit on the fourth
    add(0, 1, 0, 2'b01, 0, 0, 0, 0,    0,    0,    EN_NO,  3'b000, 0, 0, 1, 0, 0);
    add(0, 1, 0, 2'b01, 0, 0, 0, 0,    0,    0,    EN_NO,  3'b000, 1, 0, 1, 1, 0);
    add(0, 1, 0, 2'b01, 0, 0, 0, 0,    0,    0,    EN_NO,  3'b000, 1, 0, 1, 2, 0);
    add(0, 1, 1, 2'b01, 0, 0, 0, 0,    0,    0,    EN_ALL, 3'b000, 1, 0, 1, 3, 0);
    add(0, 1, 0, 2'b00, 0, 0, 0, 0,    0,    0,    EN_ALL, 3'b000, 0, 0, 1, 3, 0);
    // load-use on rt, register zero, load-use beating a fetch miss, plain fetch miss
    add(0, 1, 0, 2'b00, 0, 0, 1, 8,    3,    8,    EN_LU,  3'b010, 0, 0, 1, 3, 0);
    add(0, 1, 0, 2'b00, 0, 0, 1, 0,    0,    0,    EN_ALL, 3'b000, 0, 0, 1, 4, 0);
    add(0, 0, 0, 2'b00, 0, 0, 1, 8,    8,    1,    EN_LU,  3'b010, 0, 0, 1, 4, 0);
    add(0, 0, 0, 2'b00, 0, 0, 0, 0,    0,    0,    EN_IM,  3'b100, 0, 0, 1, 5, 0);
    // redirect with fetch miss; redirect behind a write miss
    add(0, 0, 0, 2'b00, 1, 0, 0, 0,    0,    0,    EN_ALL, 3'b111, 0, 0, 1, 6, 0);
    add(0, 1, 0, 2'b00, 0, 0, 0, 0,    0,    0,    EN_ALL, 3'b000, 0, 0, 1, 6, 1);
    add(0, 1, 0, 2'b10, 1, 0, 0, 0,    0,    0,    EN_NO,  3'b000, 0, 0, 1, 6, 1);
    add(0, 1, 1, 2'b10, 1, 0, 0, 0,    0,    0,    EN_ALL, 3'b111, 1, 0, 1, 7, 1);
    add(0, 1, 0, 2'b00, 0, 0, 0, 0,    0,    0,    EN_ALL, 3'b000, 0, 0, 1, 7, 2);
    // halt behind a data miss, frozen in HALT, reset out
    add(0, 1, 0, 2'b01, 0, 1, 0, 0,    0,    0,    EN_NO,  3'b000, 0, 0, 1, 7, 2);
    add(0, 1, 0, 2'b01, 0, 1, 0, 0,    0,    0,    EN_NO,  3'b000, 1, 0, 1, 8, 2);
    add(0, 1, 1, 2'b01, 0, 1, 0, 0,    0,    0,    EN_ALL, 3'b000, 1, 0, 1, 9, 2);
    add(0, 1, 0, 2'b00, 0, 0, 0, 0,    0,    0,    EN_NO,  3'b000, 0, 1, 1, 9, 2);
    add(0, 0, 0, 2'b00, 0, 0, 0, 0,    0,    0,    EN_NO,  3'b000, 0, 1, 1, 9, 2);
    add(0, 1, 0, 2'b00, 1, 0, 0, 0,    0,    0,    EN_NO,  3'b000, 0, 1, 1, 9, 2);
    add(1, 1, 0, 2'b00, 0, 0, 0, 0,    0,    0,    EN_NO,  3'b111, 0, 0, 1, 9, 2);
    add(0, 1, 0, 2'b00, 0, 0, 0, 0,    0,    0,    EN_ALL, 3'b000, 0, 0, 1, 0, 0);
    // direct RUN -> HALT
    add(0, 1, 0, 2'b00, 0, 1, 0, 0,    0,    0,    EN_ALL, 3'b000, 0, 0, 1, 0, 0);
    add(0, 1, 0, 2'b00, 0, 0, 0, 0,    0,    0,    EN_NO,  3'b000, 0, 1, 1, 0, 0);
    add(1, 1, 0, 2'b00, 0, 0, 0, 0,    0,    0,    EN_NO,  3'b111, 0, 0, 1, 0, 0);
    // reset in the middle of DWAIT
    add(0, 1, 0, 2'b01, 0, 0, 0, 0,    0,    0,    EN_NO,  3'b000, 0, 0, 1, 0, 0);
    add(0, 1, 0, 2'b01, 0, 0, 0, 0,    0,    0,    EN_NO,  3'b000, 1, 0, 1, 1, 0);
    add(1, 1, 0, 2'b01, 0, 0, 0, 0,    0,    0,    EN_NO,  3'b111, 0, 0, 1, 2, 0);
    add(0, 1, 0, 2'b00, 0, 0, 0, 0,    0,    0,    EN_ALL, 3'b000, 0, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      @(posedge CLK); #1;
      RST = vecs[i].rst; ihit = vecs[i].ihit; dhit = vecs[i].dhit;
      mem_dren = vecs[i].dq[0]; mem_dwen = vecs[i].dq[1];
      mem_redirect = vecs[i].redir; mem_halt = vecs[i].mhalt; ex_dren = vecs[i].exd;
      ex_wsel = vecs[i].wsel; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      sb.push_back(vecs[i]);
    end
    @(posedge CLK); #1;
    drive_idle(1'b0, 1'b1);
    @(negedge CLK);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    // Counter saturation: 20 cycles of fetch miss on both widths.
    @(posedge CLK); #1; drive_idle(1'b1, 1'b0);
    @(posedge CLK); #1; drive_idle(1'b1, 1'b0);
    @(posedge CLK); #1; drive_idle(1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      chk($sformatf("sat_small_cnt_c%0d", k), 32'(s_stall_cnt), (k > 15) ? 32'd15 : 32'(k));
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    chk("sat_small_final", 32'(s_stall_cnt), 32'd15);
    chk("sat_wide_final", 32'(stall_cnt), 32'd20);
    chk("sat_small_ctrl", 32'({s_pc_en, s_pipe1_en, s_pipe2_en, s_pipe3_en, s_pipe4_en,
                               s_flush1, s_flush2, s_flush3, s_dmem_busy, s_halted}),
        32'b0111110000);
    chk("sat_small_fcnt", 32'(s_flush_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
